// File: rtl/aes_round_key_gen.sv
// aes_round_key_gen
//   Expands a 128/256-bit cipher key into 11/15 round keys, one per clock,
//   into a 15-entry key memory. The encipher round block reads that memory
//   combinationally. While expanding, this block borrows the shared 4-byte S-box.
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous active-high reset
//   init       : start an expansion (only looked at while idle)
//   keylen     : 0 = AES-128, 1 = AES-256, captured together with init
//   key        : cipher key (AES-128 uses key[255:128]), captured with init
//   round      : index of the round key requested by the encipher block
//   round_key  : key_mem[round], combinational; 0 for round 15
//   sboxw      : word sent to the shared S-box (combinational)
//   new_sboxw  : S-box result for sboxw, returned in the same cycle
//   ready      : 1 = key memory valid and block idle
module aes_round_key_gen (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic         keylen,
  input  logic [255:0] key,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  output logic         ready
);

  localparam logic       AES_128_BIT_KEY = 1'h0;
  localparam logic       AES_256_BIT_KEY = 1'h1;
  localparam logic [3:0] AES128_ROUNDS   = 4'ha;
  localparam logic [3:0] AES256_ROUNDS   = 4'he;

  localparam int unsigned KEY_W    = 256;
  localparam int unsigned BLK_W    = 128;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned CTR_W    = 4;
  localparam int unsigned NUM_KEYS = 15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GEN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               ready_q, ready_d;
  logic [CTR_W-1:0]   round_ctr_q, round_ctr_d;
  logic [7:0]         rcon_q, rcon_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic               keylen_q, keylen_d;
  logic [BLK_W-1:0]   prev_q, prev_d;
  logic [BLK_W-1:0]   pprev_q, pprev_d;
  logic [BLK_W-1:0]   key_mem_q [NUM_KEYS];
  logic [BLK_W-1:0]   key_mem_d [NUM_KEYS];

  logic [CTR_W-1:0]   last_round;
  logic               sbox_use;
  logic               use_rcon;
  logic [BLK_W-1:0]   base_key;
  logic [WORD_W-1:0]  t_word;
  logic [WORD_W-1:0]  k0, k1, k2, k3;
  logic [BLK_W-1:0]   new_key;
  logic [7:0]         rcon_next;

  assign last_round = (keylen_q == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
  assign rcon_next  = {rcon_q[6:0], 1'b0} ^ (8'h1b & {8{rcon_q[7]}});
  assign ready      = ready_q;

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      round_ctr_q <= '0;
      rcon_q      <= 8'h01;
      key_q       <= '0;
      keylen_q    <= 1'b0;
      prev_q      <= '0;
      pprev_q     <= '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        key_mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      round_ctr_q <= round_ctr_d;
      rcon_q      <= rcon_d;
      key_q       <= key_d;
      keylen_q    <= keylen_d;
      prev_q      <= prev_d;
      pprev_q     <= pprev_d;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        key_mem_q[i] <= key_mem_d[i];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (init) state_d = ST_GEN;
      ST_GEN:  if (round_ctr_q == last_round) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Round key computation for the entry at round_ctr_q
  always_comb begin
    // AES-128 needs the S-box from round 1, AES-256 from round 2
    sbox_use = (keylen_q == AES_128_BIT_KEY) ? (round_ctr_q >= 4'd1) : (round_ctr_q >= 4'd2);
    // AES-256 odd rounds use SubWord alone, without rotate or rcon
    use_rcon = (keylen_q == AES_128_BIT_KEY) || !round_ctr_q[0];
    base_key = (keylen_q == AES_128_BIT_KEY) ? prev_q : pprev_q;
    t_word   = use_rcon ? ({new_sboxw[23:0], new_sboxw[31:24]} ^ {rcon_q, 24'h0})
                        : new_sboxw;
    k0 = base_key[127:96] ^ t_word;
    k1 = base_key[95:64]  ^ k0;
    k2 = base_key[63:32]  ^ k1;
    k3 = base_key[31:0]   ^ k2;
    if (round_ctr_q == 4'd0) begin
      new_key = key_q[255:128];
    end else if ((keylen_q == AES_256_BIT_KEY) && (round_ctr_q == 4'd1)) begin
      new_key = key_q[127:0];
    end else begin
      new_key = {k0, k1, k2, k3};
    end
  end

  // Output and datapath update logic
  always_comb begin
    ready_d     = ready_q;
    round_ctr_d = round_ctr_q;
    rcon_d      = rcon_q;
    key_d       = key_q;
    keylen_d    = keylen_q;
    prev_d      = prev_q;
    pprev_d     = pprev_q;
    sboxw       = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      key_mem_d[i] = key_mem_q[i];
    end
    case (state_q)
      ST_IDLE: begin
        if (init) begin
          key_d       = key;
          keylen_d    = keylen;
          round_ctr_d = '0;
          rcon_d      = 8'h01;
          ready_d     = 1'b0;
        end
      end
      ST_GEN: begin
        if (sbox_use) begin
          sboxw = prev_q[31:0];
        end
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
          if (round_ctr_q == CTR_W'(i)) key_mem_d[i] = new_key;
        end
        pprev_d     = prev_q;
        prev_d      = new_key;
        round_ctr_d = round_ctr_q + 4'd1;
        if (sbox_use && use_rcon) begin
          rcon_d = rcon_next;
        end
        if (round_ctr_q == last_round) begin
          ready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Combinational key memory read; index 15 has no entry and reads as zero
  always_comb begin
    round_key = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (round == CTR_W'(i)) round_key = key_mem_q[i];
    end
  end

endmodule

// File: tb/tb_aes_round_key_gen.sv
// Testbench for aes_round_key_gen: provides the shared S-box and checks the
// key memory against a word-oriented key-expansion model through a scoreboard queue.
module tb_aes_round_key_gen;

  logic         clk = 1'b0;
  logic         reset;
  logic         init;
  logic         keylen;
  logic [255:0] key;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  logic         ready;

  typedef struct packed {
    logic [3:0]   rnd;
    logic [127:0] val;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] exp_mem [16];
  int           n_cmp = 0;
  int           n_err = 0;

  localparam logic [255:0] KEY128  = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h0};
  localparam logic [255:0] KEY256  = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
  localparam logic [255:0] KEY_ALT = 256'hdeadbeef_01234567_89abcdef_cafef00d_55aa55aa_0f0f0f0f_f0e1d2c3_b4a59687;

  always #5 clk = ~clk;

  aes_round_key_gen dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .keylen    (keylen),
    .key       (key),
    .round     (round),
    .round_key (round_key),
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw),
    .ready     (ready)
  );

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: x^254 in GF(2^8), then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, base;
    r = 8'h01; base = x;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) r = gmul(r, base);
      base = gmul(base, base);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  always_comb new_sboxw = subword(sboxw);

  // FIPS-197 style word expansion; updates the shadow of the key memory
  task automatic model_expand(input logic [255:0] k, input logic k256);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nw;
    nk = k256 ? 8 : 4;
    nw = k256 ? 60 : 44;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nk == 8 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < nw / 4; r++) exp_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic push_expected();
    exp_q.delete();
    for (int r = 0; r < 16; r++) exp_q.push_back({4'(r), exp_mem[r]});
  endtask

  task automatic clear_expected();
    for (int r = 0; r < 16; r++) exp_mem[r] = '0;
  endtask

  task automatic check_keys(input string tag);
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      round = e.rnd;
      #1;
      n_cmp++;
      if (round_key !== e.val) begin
        n_err++;
        $display("FAIL %s round_key[%0d]: got %h expected %h", tag, e.rnd, round_key, e.val);
      end
    end
    round = 4'd0;
  endtask

  task automatic check_const(input string tag, input logic [3:0] r, input logic [127:0] v);
    round = r;
    #1;
    n_cmp++;
    if (round_key !== v) begin
      n_err++;
      $display("FAIL %s round_key[%0d]: got %h expected %h", tag, r, round_key, v);
    end
  endtask

  // Runs one expansion, checking latency and S-box traffic; optional stray init mid-run
  task automatic run_expansion(input logic [255:0] k, input logic kl, input logic inject, input string tag);
    int cycles;
    int exp_cycles;
    logic [31:0] exp_sbox;
    exp_cycles = kl ? 15 : 11;
    @(negedge clk);
    key = k; keylen = kl; init = 1'b1;
    model_expand(k, kl);
    push_expected();
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s ready_after_init: got %b expected 0", tag, ready);
    end
    n_cmp++;
    if (sboxw !== 32'h0) begin
      n_err++;
      $display("FAIL %s sboxw_round0: got %h expected 0", tag, sboxw);
    end
    cycles = 0;
    while (ready !== 1'b1 && cycles < 40) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (inject && cycles == 3) begin
        init = 1'b1; key = KEY_ALT; keylen = ~kl;
      end else begin
        init = 1'b0;
      end
      if (cycles == (kl ? 2 : 1)) begin
        exp_sbox = kl ? k[31:0] : k[159:128];
        n_cmp++;
        if (sboxw !== exp_sbox) begin
          n_err++;
          $display("FAIL %s sboxw_first: got %h expected %h", tag, sboxw, exp_sbox);
        end
      end
    end
    init = 1'b0;
    n_cmp++;
    if (cycles != exp_cycles) begin
      n_err++;
      $display("FAIL %s latency: got %0d expected %0d", tag, cycles, exp_cycles);
    end
    n_cmp++;
    if (sboxw !== 32'h0) begin
      n_err++;
      $display("FAIL %s sboxw_idle: got %h expected 0", tag, sboxw);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; init = 1'b0; keylen = 1'b0; key = '0; round = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_expected();
    push_expected();
    n_cmp++;
    if (ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset ready: got %b expected 1", ready);
    end
    n_cmp++;
    if (sboxw !== 32'h0) begin
      n_err++;
      $display("FAIL reset sboxw: got %h expected 0", sboxw);
    end
    check_keys("reset");
  endtask

  task automatic test_aes128();
    run_expansion(KEY128, 1'b0, 1'b0, "aes128");
    check_keys("aes128");
    check_const("aes128_fips", 4'd1,  128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    check_const("aes128_fips", 4'd10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
  endtask

  task automatic test_aes256();
    run_expansion(KEY256, 1'b1, 1'b0, "aes256");
    check_keys("aes256");
    check_const("aes256_fips", 4'd1,  128'h1f352c07_3b6108d7_2d9810a3_0914dff4);
    check_const("aes256_fips", 4'd14, 128'hfe4890d1_e6188d0b_046df344_706c631e);
  endtask

  task automatic test_init_ignored();
    run_expansion(KEY128, 1'b0, 1'b1, "init_ignored");
    check_keys("init_ignored");
    check_const("init_ignored_fips", 4'd10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    key = KEY128; keylen = 1'b0; init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_expected();
    push_expected();
    n_cmp++;
    if (ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid ready: got %b expected 1", ready);
    end
    check_keys("reset_mid_cleared");
    run_expansion(KEY128, 1'b0, 1'b0, "reset_mid_rerun");
    check_keys("reset_mid_rerun");
  endtask

  task automatic test_back_to_back();
    run_expansion(KEY256, 1'b1, 1'b0, "b2b_256");
    check_keys("b2b_256");
    run_expansion(KEY128, 1'b0, 1'b0, "b2b_128");
    check_keys("b2b_128");
  endtask

  // init held through completion restarts on the first idle cycle
  task automatic test_init_held();
    int cycles;
    @(negedge clk);
    key = KEY128; keylen = 1'b0; init = 1'b1;
    model_expand(KEY128, 1'b0);
    push_expected();
    @(posedge clk);
    @(negedge clk);
    cycles = 0;
    while (ready !== 1'b1 && cycles < 40) begin
      @(posedge clk); cycles++; @(negedge clk);
    end
    n_cmp++;
    if (cycles != 11) begin
      n_err++;
      $display("FAIL init_held latency1: got %0d expected 11", cycles);
    end
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_err++;
      $display("FAIL init_held restart: got ready %b expected 0", ready);
    end
    cycles = 0;
    while (ready !== 1'b1 && cycles < 40) begin
      @(posedge clk); cycles++; @(negedge clk);
    end
    n_cmp++;
    if (cycles != 11) begin
      n_err++;
      $display("FAIL init_held latency2: got %0d expected 11", cycles);
    end
    check_keys("init_held");
  endtask

  initial begin
    test_reset();
    test_aes128();
    test_aes256();
    test_init_ignored();
    test_reset_mid();
    test_back_to_back();
    test_init_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
